// File: rtl/rtc_pkg.sv
// Shared register map and bit positions for the RTC alarm/stopwatch peripheral.
package rtc_pkg;
    localparam int RTC_DATA_W = 32;

    localparam int REG_CTRL       = 0;
    localparam int REG_ALARM_CMP  = 1;
    localparam int REG_PERIOD     = 2;
    localparam int REG_STATUS     = 3;
    localparam int REG_SW_ELAPSED = 4;
    localparam int REG_NOW        = 5;

    localparam int CTRL_ALARM_EN = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_SW_RUN   = 2;

    localparam int ST_PENDING = 0;
    localparam int ST_MISSED  = 1;
endpackage

// File: rtl/rtc_stopwatch.sv
// Millisecond stopwatch: stamps the RTC count on run rising and tracks the wrap-safe difference.
module rtc_stopwatch
    import rtc_pkg::*;
#(
    parameter int DATA_W = RTC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] milisec_in,
    input  logic              run,
    output logic [DATA_W-1:0] elapsed
);
    logic              run_q, run_d;
    logic [DATA_W-1:0] start_q, start_d;
    logic [DATA_W-1:0] elapsed_q, elapsed_d;

    always_comb begin
        run_d     = run;
        start_d   = start_q;
        elapsed_d = elapsed_q;
        if (run && !run_q) begin
            start_d   = milisec_in;
            elapsed_d = '0;
        end else if (run && run_q) begin
            // Modular subtraction keeps the result correct across RTC wrap.
            elapsed_d = milisec_in - start_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q     <= 1'b0;
            start_q   <= '0;
            elapsed_q <= '0;
        end else begin
            run_q     <= run_d;
            start_q   <= start_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed = elapsed_q;
endmodule

// File: rtl/rtc_alarm_timer.sv
// Alarm compare/reload with one-shot or periodic interrupt, plus register bus front end.
module rtc_alarm_timer
    import rtc_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = RTC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] milisec_in,
    input  logic              sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);
    logic              alarm_en_q, alarm_en_d;
    logic              periodic_q, periodic_d;
    logic              sw_run_q, sw_run_d;
    logic [DATA_W-1:0] alarm_cmp_q, alarm_cmp_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic              pending_q, pending_d;
    logic              missed_q, missed_d;
    logic [DATA_W-1:0] prev_ms_q, prev_ms_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] sw_elapsed;
    logic              wr_en, rd_en, tick, fire, w1c, pending_kept;
    logic [DATA_W-1:0] rd_val;

    assign wr_en = sel & we;
    assign rd_en = sel & ~we;
    assign tick  = (milisec_in != prev_ms_q);
    assign fire  = tick & alarm_en_q & (milisec_in == alarm_cmp_q);
    assign w1c   = wr_en & (int'(addr) == REG_STATUS);

    always_comb begin
        alarm_en_d  = alarm_en_q;
        periodic_d  = periodic_q;
        sw_run_d    = sw_run_q;
        alarm_cmp_d = alarm_cmp_q;
        period_d    = period_q;
        prev_ms_d   = milisec_in;

        if (fire) begin
            if (periodic_q && (period_q != '0)) alarm_cmp_d = alarm_cmp_q + period_q;
            else                                alarm_en_d  = 1'b0;
        end

        // A fire only counts as missed if pending survives this cycle's W1C.
        pending_kept = pending_q & ~(w1c & wdata[ST_PENDING]);
        pending_d    = pending_kept | fire;
        missed_d     = (missed_q & ~(w1c & wdata[ST_MISSED])) | (fire & pending_kept);

        // Bus writes are applied last so they override the fire side effects.
        if (wr_en) begin
            case (int'(addr))
                REG_CTRL: begin
                    alarm_en_d = wdata[CTRL_ALARM_EN];
                    periodic_d = wdata[CTRL_PERIODIC];
                    sw_run_d   = wdata[CTRL_SW_RUN];
                end
                REG_ALARM_CMP: alarm_cmp_d = wdata;
                REG_PERIOD:    period_d    = wdata;
                default: ;
            endcase
        end

        // Enable as seen in the fire cycle, so a one-shot's self-clear still yields a pulse.
        irq_d = pending_d & alarm_en_q;

        case (int'(addr))
            REG_CTRL:       rd_val = {{(DATA_W-3){1'b0}}, sw_run_q, periodic_q, alarm_en_q};
            REG_ALARM_CMP:  rd_val = alarm_cmp_q;
            REG_PERIOD:     rd_val = period_q;
            REG_STATUS:     rd_val = {{(DATA_W-2){1'b0}}, missed_q, pending_q};
            REG_SW_ELAPSED: rd_val = sw_elapsed;
            REG_NOW:        rd_val = milisec_in;
            default:        rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_en_q  <= 1'b0;
            periodic_q  <= 1'b0;
            sw_run_q    <= 1'b0;
            alarm_cmp_q <= '0;
            period_q    <= '0;
            pending_q   <= 1'b0;
            missed_q    <= 1'b0;
            prev_ms_q   <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            alarm_en_q  <= alarm_en_d;
            periodic_q  <= periodic_d;
            sw_run_q    <= sw_run_d;
            alarm_cmp_q <= alarm_cmp_d;
            period_q    <= period_d;
            pending_q   <= pending_d;
            missed_q    <= missed_d;
            prev_ms_q   <= prev_ms_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    // Stamping from the next run value starts timing at the CTRL write edge itself.
    rtc_stopwatch #(.DATA_W(DATA_W)) u_sw (
        .clk        (clk),
        .rst        (rst),
        .milisec_in (milisec_in),
        .run        (sw_run_d),
        .elapsed    (sw_elapsed)
    );

    assign rdata = rdata_q;
    assign irq   = irq_q;
endmodule

// File: tb/tb_rtc_alarm_timer.sv
// Directed bench: reads feed a scoreboard queue checked by a monitor one cycle later.
module tb_rtc_alarm_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] milisec_in = '0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_issued = 1'b0;

    always #5 clk = ~clk;

    rtc_alarm_timer #(.ADDR_W(3), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .milisec_in (milisec_in),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq)
    );

    // Monitor: a read accepted at a rising edge presents rdata for the following cycle.
    always @(posedge clk) rd_issued <= sel && !we && rst;

    always @(negedge clk) begin
        if (rd_issued) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected rdata=%h with no expected entry", rdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL %s rdata=%h expected=%h", n, rdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ms(input logic [2:0] a, input logic [31:0] d, input logic [31:0] ms);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d; milisec_in = ms;
        step();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_ms(a, d, milisec_in);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        sel = 1'b1; we = 1'b0; addr = a;
        step();
        sel = 1'b0;
    endtask

    task automatic ms(input logic [31:0] v);
        milisec_in = v;
        step();
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, act, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b1;
        step();
        for (int i = 0; i < 8; i++) rd(3'(i), 0, "rst_reg");

        // One-shot
        wr(1, 100);
        wr(0, 1);
        ms(98);
        ms(99);
        chk("os_irq_pre", {31'b0, irq}, 0);
        ms(100);
        chk("os_irq_fire", {31'b0, irq}, 1);
        step();
        chk("os_irq_drop", {31'b0, irq}, 0);
        rd(3, 1, "os_status");
        rd(0, 0, "os_ctrl_cleared");
        wr(3, 1);
        wr(0, 1);
        repeat (5) step();
        rd(3, 0, "os_no_refire");
        chk("os_irq_hold", {31'b0, irq}, 0);
        wr(0, 0);

        // Periodic across wrap
        wr(1, 32'hFFFF_FFFE);
        wr(2, 4);
        wr(0, 3);
        ms(32'hFFFF_FFFD);
        ms(32'hFFFF_FFFE);
        chk("per_irq_fire", {31'b0, irq}, 1);
        rd(1, 32'h2, "per_cmp_wrap");
        wr(3, 1);
        chk("per_irq_clr", {31'b0, irq}, 0);
        ms(32'hFFFF_FFFF);
        ms(0);
        ms(1);
        rd(3, 0, "per_status_idle");
        ms(2);
        chk("per_irq_fire2", {31'b0, irq}, 1);
        rd(3, 1, "per_status_fire2");
        rd(1, 6, "per_cmp_reload2");

        // Missed alarms and simultaneous events
        wr(2, 1);
        wr(1, 10);
        wr(3, 3);
        wr(0, 3);
        ms(10);
        ms(11);
        rd(3, 3, "miss_status");
        wr_ms(3, 3, 12);
        rd(3, 1, "miss_w1c_vs_fire");
        wr_ms(1, 50, 13);
        rd(1, 50, "cmp_write_wins");
        wr(3, 3);
        wr(0, 1);
        wr(1, 60);
        wr_ms(0, 1, 60);
        rd(0, 1, "ctrl_write_wins");
        rd(3, 1, "ctrl_fire_pending");
        wr(0, 0);
        wr(3, 3);

        // Stopwatch
        ms(500);
        wr(0, 4);
        ms(750);
        rd(4, 250, "sw_run");
        ms(800);
        wr(0, 0);
        ms(900);
        rd(4, 300, "sw_frozen");
        ms(32'hFFFF_FFF0);
        wr(0, 4);
        ms(32'h10);
        rd(4, 32'h20, "sw_wrap");
        wr(0, 4);
        ms(32'h20);
        rd(4, 32'h30, "sw_rewrite_noop");
        wr(0, 0);

        // Read latency and unmapped addresses
        ms(1234);
        rd(5, 1234, "now_read");
        rd(7, 0, "unmapped_rd");
        wr(6, 32'hFFFF_FFFF);
        rd(0, 0, "unm_ctrl");
        rd(1, 60, "unm_cmp");
        rd(2, 1, "unm_period");
        rd(3, 0, "unm_status");

        // Async reset mid-operation with pending set
        wr(1, 2000);
        wr(2, 5);
        wr(0, 3);
        ms(2000);
        chk("mid_irq_fire", {31'b0, irq}, 1);
        rd(5, 2000, "mid_now");
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_irq", {31'b0, irq}, 0);
        chk("mid_rst_rdata", rdata, 0);
        milisec_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        for (int i = 0; i < 8; i++) rd(3'(i), 0, "post_rst_reg");
        chk("post_rst_irq", {31'b0, irq}, 0);

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
